// File: rtl/hamming_rx_sink_if.sv
// Handshake bundle between the SECDED decoder, the rx sink and its consumer.
// HAMMING_DED_PASS_EN adds out_uncorr for DED words passed through the FIFO.
interface hamming_rx_sink_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] codeword;
    logic        sed;
    logic        ded;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic        out_corr;
`ifdef HAMMING_DED_PASS_EN
    logic        out_uncorr;

    modport master (
        output in_valid, codeword, sed, ded, out_ready,
        input  in_ready, out_valid, out_data, out_corr, out_uncorr
    );
    modport slave (
        input  in_valid, codeword, sed, ded, out_ready,
        output in_ready, out_valid, out_data, out_corr, out_uncorr
    );
`else
    modport master (
        output in_valid, codeword, sed, ded, out_ready,
        input  in_ready, out_valid, out_data, out_corr
    );
    modport slave (
        input  in_valid, codeword, sed, ded, out_ready,
        output in_ready, out_valid, out_data, out_corr
    );
`endif
endinterface

// File: rtl/hamming_rx_sink.sv
// Hamming(16,11) receive sink: parity strip, output FIFO, SED/DED statistics, link-health FSM.
// HAMMING_DED_PASS_EN: DED words are buffered (flagged via out_uncorr) instead of dropped.
module hamming_rx_sink #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned ALARM_THRESH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    hamming_rx_sink_if.slave   bus,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   sed_cnt,
    output logic [CNT_W-1:0]   ded_cnt,
    output logic [1:0]         health,
    output logic               alarm
);
    localparam int unsigned AW = $clog2(DEPTH);
`ifdef HAMMING_DED_PASS_EN
    localparam int unsigned EW = 13;
`else
    localparam int unsigned EW = 12;
`endif
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [8:0]       THRESH  = 9'(ALARM_THRESH);

    typedef enum logic [1:0] {
        StHealthy  = 2'b00,
        StDegraded = 2'b01,
        StFailed   = 2'b10
    } health_e;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] sed_cnt_q, sed_cnt_d, ded_cnt_q, ded_cnt_d;
    logic [7:0]       run_q, run_d;
    health_e          state_q, state_d;

    logic          full, empty, accept, push, pop;
    logic          is_sed, is_ded, is_clean;
    logic [10:0]   data_in;
    logic [EW-1:0] entry_in, head;
    logic [8:0]    run_inc;
    logic          unused_parity;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // in_ready depends on registered pointers only, so a pop cannot open a slot the same cycle.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;

    assign accept   = bus.in_valid && !full;
    assign is_ded   = bus.ded;
    assign is_sed   = bus.sed && !bus.ded;
    assign is_clean = !bus.sed && !bus.ded;
    assign pop      = !empty && bus.out_ready;

    assign data_in = {bus.codeword[3],  bus.codeword[5],  bus.codeword[6],  bus.codeword[7],
                      bus.codeword[9],  bus.codeword[10], bus.codeword[11], bus.codeword[12],
                      bus.codeword[13], bus.codeword[14], bus.codeword[15]};
    assign unused_parity = ^{bus.codeword[0], bus.codeword[1], bus.codeword[2],
                             bus.codeword[4], bus.codeword[8]};

`ifdef HAMMING_DED_PASS_EN
    assign push     = accept;
    assign entry_in = {is_ded, data_in, is_sed};
`else
    assign push     = accept && !is_ded;
    assign entry_in = {data_in, is_sed};
`endif

    assign head         = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.out_data = empty ? 11'd0 : head[11:1];
    assign bus.out_corr = empty ? 1'b0 : head[0];
`ifdef HAMMING_DED_PASS_EN
    assign bus.out_uncorr = empty ? 1'b0 : head[12];
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Clear has priority; an increment in the same cycle is lost.
    always_comb begin
        sed_cnt_d = sed_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (cnt_clr) begin
            sed_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (accept) begin
            if (is_sed && (sed_cnt_q != '1)) sed_cnt_d = sed_cnt_q + CNT_ONE;
            if (is_ded && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + CNT_ONE;
        end
    end

    assign run_inc = {1'b0, run_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (cnt_clr) begin
            state_d = StHealthy;
            run_d   = '0;
        end else if (accept) begin
            case (state_q)
                StHealthy: begin
                    if (is_ded) begin
                        run_d   = 8'd1;
                        state_d = (THRESH <= 9'd1) ? StFailed : StDegraded;
                    end
                end
                StDegraded: begin
                    if (is_ded) begin
                        run_d = run_inc[7:0];
                        if (run_inc >= THRESH) state_d = StFailed;
                    end else if (is_sed) begin
                        run_d = '0;
                    end else if (is_clean) begin
                        run_d   = '0;
                        state_d = StHealthy;
                    end
                end
                StFailed: ;
                default: begin
                    state_d = StHealthy;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            sed_cnt_q <= '0;
            ded_cnt_q <= '0;
            run_q     <= '0;
            state_q   <= StHealthy;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            sed_cnt_q <= sed_cnt_d;
            ded_cnt_q <= ded_cnt_d;
            run_q     <= run_d;
            state_q   <= state_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry_in;
    end

    assign sed_cnt = sed_cnt_q;
    assign ded_cnt = ded_cnt_q;
    assign health  = state_q;
    assign alarm   = (state_q == StFailed);

endmodule

// File: tb/tb_hamming_rx_sink.sv
// Directed, table-driven bench for hamming_rx_sink (DEPTH=4, CNT_W=4, ALARM_THRESH=3).
module tb_hamming_rx_sink;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned THRESH = 3;
`ifdef HAMMING_DED_PASS_EN
    localparam bit DED_PASS = 1'b1;
`else
    localparam bit DED_PASS = 1'b0;
`endif

    typedef struct {
        logic [15:0] cw;
        logic        sed;
        logic        ded;
        logic        vld;
        logic [10:0] data;
        logic        corr;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] sed_cnt, ded_cnt;
    logic [1:0]       health;
    logic             alarm;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int corr_pops = 0;
    bit mon_en = 1'b0;

    vec_t vecs[9];

    always #5 clk = ~clk;

    hamming_rx_sink_if bus ();

    hamming_rx_sink #(
        .DEPTH        (DEPTH),
        .CNT_W        (CNT_W),
        .ALARM_THRESH (THRESH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .cnt_clr (cnt_clr),
        .sed_cnt (sed_cnt),
        .ded_cnt (ded_cnt),
        .health  (health),
        .alarm   (alarm)
    );

    always @(posedge clk) begin
        if (mon_en && bus.out_valid && bus.out_ready) begin
            pops++;
            if (bus.out_corr) corr_pops++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] cw, input logic s, input logic d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.codeword = cw;
        bus.sed      = s;
        bus.ded      = d;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check("send_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.sed      = 1'b0;
        bus.ded      = 1'b0;
    endtask

    task automatic clear();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        logic [10:0] exp_d;
        int exp_sed;
        int exp_ded;

        vecs[0] = '{16'hFFF7, 1'b0, 1'b0, 1'b1,     11'h3FF, 1'b0};
        vecs[1] = '{16'h0008, 1'b1, 1'b0, 1'b1,     11'h400, 1'b1};
        vecs[2] = '{16'h8000, 1'b0, 1'b0, 1'b1,     11'h001, 1'b0};
        vecs[3] = '{16'h0117, 1'b0, 1'b0, 1'b1,     11'h000, 1'b0};
        vecs[4] = '{16'hFEE8, 1'b1, 1'b1, DED_PASS, 11'h7FF, 1'b0};
        vecs[5] = '{16'hFEE8, 1'b0, 1'b0, 1'b1,     11'h7FF, 1'b0};
        vecs[6] = '{16'h00E0, 1'b1, 1'b0, 1'b1,     11'h380, 1'b1};
        vecs[7] = '{16'h0E00, 1'b0, 1'b0, 1'b1,     11'h070, 1'b0};
        vecs[8] = '{16'h5000, 1'b0, 1'b0, 1'b1,     11'h00A, 1'b0};

        bus.in_valid  = 1'b0;
        bus.codeword  = 16'h0;
        bus.sed       = 1'b0;
        bus.ded       = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_corr",  32'(bus.out_corr),  32'd0);
        check("rst_sed_cnt",   32'(sed_cnt),       32'd0);
        check("rst_ded_cnt",   32'(ded_cnt),       32'd0);
        check("rst_health",    32'(health),        32'd0);
        check("rst_alarm",     32'(alarm),         32'd0);
        rst_n = 1'b1;

        // Extraction table: one word at a time through an empty FIFO.
        exp_sed = 0;
        exp_ded = 0;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].cw, vecs[i].sed, vecs[i].ded);
            if (vecs[i].ded) exp_ded++;
            else if (vecs[i].sed) exp_sed++;
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].vld));
            if (vecs[i].vld) begin
                check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].data));
                check($sformatf("vec%0d_corr", i), 32'(bus.out_corr), 32'(vecs[i].corr));
                bus.out_ready = 1'b1;
                step();
                bus.out_ready = 1'b0;
            end
            check($sformatf("vec%0d_empty", i), 32'(bus.out_valid), 32'd0);
        end
        check("tbl_sed_cnt", 32'(sed_cnt), 32'(exp_sed));
        check("tbl_ded_cnt", 32'(ded_cnt), 32'(exp_ded));
        check("tbl_health",  32'(health),  32'd0);

        // Full / backpressure.
        send(16'h8000, 1'b0, 1'b0);
        send(16'h4000, 1'b0, 1'b0);
        send(16'h2000, 1'b0, 1'b0);
        send(16'h1000, 1'b0, 1'b0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.codeword = 16'h0800;
        step();
        step();
        check("full_hold_ready", 32'(bus.in_ready), 32'd0);
        check("full_hold_data",  32'(bus.out_data), 32'h001);
        bus.out_ready = 1'b1;
        #1;
        check("full_no_comb_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("pop1_ready", 32'(bus.in_ready), 32'd1);
        check("pop1_data",  32'(bus.out_data), 32'h002);
        step();
        bus.in_valid = 1'b0;
        check("pop2_data", 32'(bus.out_data), 32'h004);
        step();
        check("pop3_data", 32'(bus.out_data), 32'h008);
        step();
        check("pop4_data", 32'(bus.out_data), 32'h010);
        step();
        check("drain_empty", 32'(bus.out_valid), 32'd0);

        // Counters with a live consumer; pops are tallied by the monitor.
        clear();
        pops = 0;
        corr_pops = 0;
        mon_en = 1'b1;
        send(16'h8000, 1'b1, 1'b0);
        send(16'h8000, 1'b0, 1'b1);
        send(16'h8000, 1'b1, 1'b0);
        send(16'h8000, 1'b1, 1'b1);
        send(16'h8000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        mon_en = 1'b0;
        check("cnt_sed", 32'(sed_cnt), 32'd3);
        check("cnt_ded", 32'(ded_cnt), 32'd2);
        check("cnt_pops", 32'(pops), DED_PASS ? 32'd5 : 32'd3);
        check("cnt_corr_pops", 32'(corr_pops), 32'd3);

        // Clear wins over a same-cycle DED accept.
        cnt_clr = 1'b1;
        send(16'h8000, 1'b0, 1'b1);
        cnt_clr = 1'b0;
        check("clr_ded_cnt", 32'(ded_cnt), 32'd0);
        check("clr_sed_cnt", 32'(sed_cnt), 32'd0);
        check("clr_health",  32'(health),  32'd0);

        // Saturation at 2^CNT_W-1.
        for (int i = 0; i < 20; i++) begin
            send(16'h8000, 1'b1, 1'b0);
            if (i == 13) check("sat_cnt14", 32'(sed_cnt), 32'd14);
        end
        check("sat_cnt_hold", 32'(sed_cnt), 32'd15);

        // Health FSM.
        clear();
        send(16'h8000, 1'b0, 1'b1);
        check("h_ded1", 32'(health), 32'd1);
        send(16'h8000, 1'b0, 1'b0);
        check("h_clean", 32'(health), 32'd0);
        send(16'h8000, 1'b0, 1'b1);
        send(16'h8000, 1'b1, 1'b0);
        check("h_sed_stay", 32'(health), 32'd1);
        send(16'h8000, 1'b0, 1'b1);
        send(16'h8000, 1'b0, 1'b1);
        check("h_run2", 32'(health), 32'd1);
        check("h_run2_alarm", 32'(alarm), 32'd0);
        send(16'h8000, 1'b0, 1'b1);
        check("h_failed", 32'(health), 32'd2);
        check("h_alarm", 32'(alarm), 32'd1);
        for (int i = 0; i < 10; i++) send(16'h8000, 1'b0, 1'b0);
        check("h_sticky", 32'(health), 32'd2);
        check("h_ded_cnt", 32'(ded_cnt), 32'd5);
        clear();
        check("h_clr_health", 32'(health), 32'd0);
        check("h_clr_alarm",  32'(alarm),  32'd0);

`ifdef HAMMING_DED_PASS_EN
        bus.out_ready = 1'b0;
        send(16'h8000, 1'b1, 1'b1);
        check("pass_valid",  32'(bus.out_valid),  32'd1);
        check("pass_uncorr", 32'(bus.out_uncorr), 32'd1);
        check("pass_corr",   32'(bus.out_corr),   32'd0);
        check("pass_data",   32'(bus.out_data),   32'h001);
        check("pass_ded_cnt", 32'(ded_cnt), 32'd1);
        bus.out_ready = 1'b1;
        step();
`endif

        // Reset mid-operation discards buffered words.
        bus.out_ready = 1'b0;
        send(16'h8000, 1'b1, 1'b0);
        send(16'h4000, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_valid",   32'(bus.out_valid), 32'd0);
        check("mid_rst_ready",   32'(bus.in_ready),  32'd1);
        check("mid_rst_data",    32'(bus.out_data),  32'd0);
        check("mid_rst_sed_cnt", 32'(sed_cnt),       32'd0);
        step();
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_rx_sink.md
# hamming_rx_sink

Receive-side stage directly downstream of the Hamming(16,11) SECDED decoder. Takes each corrected 16-bit codeword with its `sed`/`ded` flags over a valid/ready handshake and strips the five parity bits to recover the 11 data bits. It buffers the data in a small FIFO for the consumer and keeps saturating SED/DED statistics. A link-health state machine raises a sticky alarm on bursts of uncorrectable words.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of each error counter.
- `ALARM_THRESH`, 3: consecutive accepted DED words that force FAILED; range 1..255.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  decoder output word valid.
- `in_ready`  out  1  sink can accept a word.
- `codeword`  in  16  corrected codeword from decoder.
- `sed`  in  1  single error detected (and corrected) for this word.
- `ded`  in  1  double error detected for this word.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts head.
- `out_data`  out  11  extracted data of FIFO head.
- `out_corr`  out  1  head word had a corrected single error.
- `cnt_clr`  in  1  clear counters and health state.
- `sed_cnt`  out  CNT_W  accepted SED words, saturating.
- `ded_cnt`  out  CNT_W  accepted DED words, saturating.
- `health`  out  2  00 HEALTHY, 01 DEGRADED, 10 FAILED.
- `alarm`  out  1  high iff `health`==FAILED.

## Operation
- Accept: `in_valid & in_ready`. `in_ready = !full`. This is independent of `ded`; dropped words also need `in_ready`.
- Flag classification:
  - `ded`=1 makes the word DED, regardless of `sed`.
  - `sed`=1 and `ded`=0 makes it SED.
  - Both 0 makes it clean.
- Extraction, MSB first:
  - `out_data[10:0]` = {cw[3], cw[5], cw[6], cw[7], cw[9], cw[10], cw[11], cw[12], cw[13], cw[14], cw[15]}.
  - Bits cw[0], cw[1], cw[2], cw[4], cw[8] are discarded.
- FIFO:
  - An accepted clean or SED word is written as {data, corr}, with corr=1 for SED.
  - An accepted DED word is not written (see Configuration).
  - Pop on `out_valid & out_ready`.
  - Pointers are log2(DEPTH) bits plus a wrap bit and wrap modulo DEPTH.
  - full when the pointer indices are equal and the wrap bits differ.
- Counters:
  - Accepted SED increments `sed_cnt`; accepted DED increments `ded_cnt`.
  - Each holds at 2^CNT_W−1.
  - `cnt_clr` zeroes both and wins over a same-cycle increment; that event is lost.
- Health FSM, with internal run counter `run` (8 bits):
  - HEALTHY: accepted DED sets `run`=1 and goes to DEGRADED. If ALARM_THRESH==1, it goes straight to FAILED.
  - DEGRADED, accepted DED: `run`+1. If `run`+1 ≥ ALARM_THRESH, go to FAILED.
  - DEGRADED, accepted SED: `run`=0, stay in DEGRADED.
  - DEGRADED, accepted clean word: `run`=0, go to HEALTHY.
  - FAILED: sticky; only `cnt_clr` or reset leaves it.
  - `cnt_clr`: go to HEALTHY, `run`=0, from any state; priority over same-cycle events.
  - Cycles without an accept do not change state.

## Timing
- Reset values (`rst_n`=0 at an edge):
  - `out_valid`=0, `in_ready`=1.
  - `out_data`=0, `out_corr`=0.
  - `sed_cnt`=0, `ded_cnt`=0.
  - `health`=00, `alarm`=0.
  - FIFO empty, `run`=0.
- Reset mid-operation discards all buffered words; nothing is flushed.
- Latency: a word accepted at edge N is visible on `out_valid`/`out_data` after edge N (1 cycle) if the FIFO was empty.
- `in_ready` is derived from registered pointers only; no combinational path from `out_ready`.
- Full with a same-cycle pop: no push that cycle (`in_ready`=0). `in_ready` rises after the pop edge.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged.
- Empty with a push: no bypass; `out_valid` rises next cycle.
- `out_data`/`out_corr` hold stable while `out_valid & !out_ready`.
- Counters, `health` and `alarm` update on the edge at which the accept or clear happens.

## Configuration
- `HAMMING_DED_PASS_EN` defined:
  - DED words are written to the FIFO.
  - An extra output `out_uncorr` (1 bit, reset 0) is added and is set for those entries.
  - FIFO entry width becomes 13.
- `HAMMING_DED_PASS_EN` undefined: DED words are dropped after counting, and `out_uncorr` does not exist.
- Counters and FSM behave identically in both builds.

## Test plan
- **Reset and passthrough:** after reset, send cw=16'hFFF7 (cw[3]=0), clean; `out_ready`=1 → `out_valid` next cycle, `out_data`=11'h3FF... wait, cw[3] is MSB → `out_data`=11'h3FF with bit10=0, i.e. 11'h3FF; `out_corr`=0.
- **Full/backpressure:** hold `out_ready`=0 and push 5 clean words with DEPTH=4 → `in_ready`=0 after the 4th accept. Release → words drain in order, and `in_ready` returns 1 cycle after the first pop.
- **Counters:**
  - 3 SED and 2 DED words → `sed_cnt`=3, `ded_cnt`=2. Only 3 words appear at the output, all with `out_corr`=1 (undefined-macro build).
  - Assert `cnt_clr` together with a DED accept → `ded_cnt`=0.
- **Saturation:** with CNT_W=4, send 20 SED words → `sed_cnt` holds at 15.
- **Health FSM (ALARM_THRESH=3):**
  - DED, clean → HEALTHY.
  - DED, SED, DED, DED → still DEGRADED (`run`=2).
  - A 3rd consecutive DED → FAILED, `alarm`=1.
  - 10 clean words → still FAILED.
  - `cnt_clr` → HEALTHY next cycle.
- **Macro build:** with `HAMMING_DED_PASS_EN`, a DED word appears at the output with `out_uncorr`=1, and `ded_cnt` still increments.
